// File: rtl/mem_access_unit.sv
// Processor-side initiator for the memory system. It captures one load or store,
// holds it on the mem_system interface until Done, err or timeout, then reports data and status.
module mem_access_unit #(
    parameter int TIMEOUT     = 64,    // legal range 2..255
    parameter bit CHECK_ALIGN = 1'b1,
    parameter int CNT_W       = 16     // counters saturate at 2**CNT_W-1 (1..16)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_rd,
    input  logic        pipe_wr,
    input  logic [15:0] pipe_addr,
    input  logic [15:0] pipe_wdata,
    output logic        pipe_stall,
    output logic        pipe_done,
    output logic [15:0] pipe_rdata,
    output logic        pipe_err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_dataout,
    input  logic        mem_done,
    input  logic        mem_stall,
    input  logic        mem_cachehit,
    input  logic        mem_err,
    output logic [15:0] access_cnt,
    output logic [15:0] hit_cnt,
    output logic [1:0]  dbg_state
);

    // Pipeline handshake: a request (pipe_rd|pipe_wr) is held by the pipeline while
    // pipe_stall=1; it is consumed in IDLE and answered by a one-cycle pipe_done
    // (pipe_err qualifies it). Memory side: exactly one of mem_rd/mem_wr is held with
    // stable mem_addr/mem_wdata until mem_done or mem_err is sampled.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [15:0] CNT_MAX  = 16'((32'd1 << CNT_W) - 32'd1);

    state_t      state;
    logic [7:0]  tmo_cnt;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        req;
    logic        illegal;
    logic        timed_out;
    logic        unused_mem_stall;

    assign req        = pipe_rd | pipe_wr;
    assign illegal    = (pipe_rd & pipe_wr) | (CHECK_ALIGN & pipe_addr[0]);
    assign timed_out  = (tmo_cnt == TMO_LAST);
    assign pipe_stall = (state == BUSY) | ((state == IDLE) & req);
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign dbg_state  = state;

    // Stall from mem_system is informational; mem_done alone ends an access.
    assign unused_mem_stall = mem_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            pipe_done  <= 1'b0;
            pipe_err   <= 1'b0;
            pipe_rdata <= '0;
            access_cnt <= '0;
            hit_cnt    <= '0;
        end else begin
            pipe_done <= 1'b0;
            pipe_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (illegal) begin
                            state     <= ERR;
                            pipe_done <= 1'b1;
                            pipe_err  <= 1'b1;
                        end else begin
                            addr_q  <= pipe_addr;
                            wdata_q <= pipe_wdata;
                            mem_rd  <= pipe_rd;
                            mem_wr  <= pipe_wr;
                            tmo_cnt <= '0;
                            state   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (mem_err || mem_done || timed_out) begin
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                    end
                    // mem_err outranks mem_done, which outranks the timeout.
                    if (mem_err) begin
                        state     <= ERR;
                        pipe_done <= 1'b1;
                        pipe_err  <= 1'b1;
                    end else if (mem_done) begin
                        if (mem_rd) begin
                            pipe_rdata <= mem_dataout;
                        end
                        if (access_cnt != CNT_MAX) begin
                            access_cnt <= access_cnt + 16'd1;
                        end
                        if (mem_cachehit && (hit_cnt != CNT_MAX)) begin
                            hit_cnt <= hit_cnt + 16'd1;
                        end
                        state     <= RESP;
                        pipe_done <= 1'b1;
                    end else if (timed_out) begin
                        state     <= ERR;
                        pipe_done <= 1'b1;
                        pipe_err  <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: begin
                    // RESP and ERR last one cycle; held pipeline inputs are ignored here.
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Processor-side initiator for the data/instruction memory system. It sits between the pipeline memory stage and the mem_system request interface (Addr/DataIn/Rd/Wr in; DataOut/Done/Stall/CacheHit/err out). It captures one load or store, holds it stable until the memory system signals completion, stalls the pipeline meanwhile, and returns read data and error status. It also keeps access and hit counters for performance dumps.

Parameters:
TIMEOUT, 64, max cycles in BUSY without mem_done before the request is aborted with an error; legal range 2..255.
CHECK_ALIGN, 1, when 1 an odd address on a request is flagged as an error and never issued to memory.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
pipe_rd  input  1  pipeline load request
pipe_wr  input  1  pipeline store request
pipe_addr  input  16  request byte address
pipe_wdata  input  16  store data
pipe_stall  output  1  hold pipeline memory stage
pipe_done  output  1  one-cycle completion pulse
pipe_rdata  output  16  load result, valid when pipe_done=1 for a load
pipe_err  output  1  error with completion, valid when pipe_done=1
mem_addr  output  16  to mem_system Addr
mem_wdata  output  16  to mem_system DataIn
mem_rd  output  1  to mem_system Rd
mem_wr  output  1  to mem_system Wr
mem_dataout  input  16  from mem_system DataOut
mem_done  input  1  from mem_system Done
mem_stall  input  1  from mem_system Stall (monitor only)
mem_cachehit  input  1  from mem_system CacheHit
mem_err  input  1  from mem_system err
access_cnt  output  16  completed accesses, saturating
hit_cnt  output  16  completed accesses with mem_cachehit=1, saturating

Behaviour:
- States: IDLE, BUSY, RESP, ERR. Reset value: IDLE. All outputs 0, counters 0, request/rdata registers 0.
- IDLE, no request (pipe_rd=pipe_wr=0): pipe_stall=0. mem_rd=mem_wr=0.
- IDLE, illegal request (pipe_rd=pipe_wr=1, or CHECK_ALIGN=1 and pipe_addr[0]=1): go to ERR. pipe_stall=1 this cycle. No memory request is issued.
- IDLE, legal request: latch addr, wdata and op into registers. Go to BUSY. pipe_stall=1 combinationally this cycle. Clear the timeout counter.
- BUSY:
  - mem_addr/mem_wdata come from the latched registers. Exactly one of mem_rd/mem_wr is 1, held constant every cycle until mem_done is sampled. pipe_stall=1.
  - Request latency is one cycle: mem_rd/mem_wr first assert the cycle after acceptance.
- BUSY, mem_done=1 and mem_err=0:
  - Load: latch mem_dataout into pipe_rdata. Store: pipe_rdata unchanged.
  - access_cnt+1. hit_cnt+1 if mem_cachehit=1. Both saturate at 16'hFFFF.
  - Go to RESP.
  - The mem_rd/mem_wr assertion in this same cycle is permitted, because mem_system is Done-terminated. They deassert from the next cycle.
- BUSY, mem_err=1 (any cycle, with or without mem_done): go to ERR. Counters are unchanged.
- BUSY, timeout counter reaches TIMEOUT-1 without mem_done: go to ERR. mem_rd/mem_wr drop next cycle.
- RESP: pipe_done=1, pipe_err=0, pipe_stall=0, mem_rd=mem_wr=0. Always go to IDLE next cycle. Pipeline inputs are ignored in RESP, so a held request is not reissued.
- ERR: pipe_done=1, pipe_err=1, pipe_stall=0, mem_rd=mem_wr=0. Go to IDLE.
- Simultaneous mem_done and timeout expiry: mem_done wins.
- mem_stall is not used for control. mem_done is the only completion indication.
- rst asserted mid-operation: immediate async return to IDLE. mem_rd/mem_wr drop without waiting for the clock. Counters clear.
- Minimum throughput: one access per 3 cycles (IDLE, BUSY, RESP) when mem_done arrives on the first BUSY cycle.

Test Plan:
- Load hit: pipe_rd=1, addr=16'h0024, mem_done+mem_cachehit on the 1st BUSY cycle with dataout=16'hBEEF -> mem_rd high exactly 1 cycle; pipe_done on cycle 3 with rdata=16'hBEEF; access_cnt=1, hit_cnt=1.
- Store miss: pipe_wr=1, addr=16'h1000, wdata=16'h1234, mem_done after 10 cycles, cachehit=0 -> mem_wr/mem_addr/mem_wdata stable for 10 cycles; pipe_stall high throughout; pipe_done, pipe_err=0; hit_cnt unchanged.
- Misaligned load addr=16'h0003 -> mem_rd never asserts; next cycle pipe_done=1, pipe_err=1. pipe_rd=pipe_wr=1 gives the same result.
- Timeout, TIMEOUT=8, mem_done never asserts -> mem_rd high 8 cycles then low; pipe_done=pipe_err=1 on the following cycle.
- mem_err=1 on the 3rd BUSY cycle -> ERR response; access_cnt unchanged.
- rst low during BUSY -> mem_rd low immediately (before the next edge), all counters 0. Separately, preload access_cnt at 16'hFFFF via back-to-back hits -> stays 16'hFFFF.
